// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode/funct
// values, ALU op codes (also used by the ALU) and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_ren;
        logic       mem_wen;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_funct.sv
// R-type funct decoder: maps funct to an ALU op, flags unsupported codes
// (which fall back to ADD so the ALU still sees a defined op).
module alu_funct_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] funct,
    output logic [3:0]     alu_op,
    output logic           illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            OPW'(FN_ADD): alu_op = ALU_ADD;
            OPW'(FN_SUB): alu_op = ALU_SUB;
            OPW'(FN_AND): alu_op = ALU_AND;
            OPW'(FN_OR):  alu_op = ALU_OR;
            OPW'(FN_NOR): alu_op = ALU_NOR;
            OPW'(FN_SLT): alu_op = ALU_SLT;
            default:      illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM. Outputs are registered from the next-state decode;
// only the branch pc_write (needs live zero) and the DECODE illegal-opcode pulse
// (IR is loaded on the FETCH->DECODE edge) are combinational.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int O   = 4,
    parameter int OPW = 6
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    input  logic           zero,
    output logic           pc_write,
    output logic           iord,
    output logic           mem_ren,
    output logic           mem_wen,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     pc_source,
    output logic [O-1:0]   alu_op,
    output logic           instr_done,
    output logic           illegal
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [3:0] fn_alu_op;
    logic       fn_illegal;
    logic       op_r, op_lw, op_sw, op_beq, op_bne, op_addi, op_j, op_legal;

    alu_funct_decode #(.OPW(OPW)) u_funct_decode (
        .funct   (funct),
        .alu_op  (fn_alu_op),
        .illegal (fn_illegal)
    );

    always_comb begin
        op_r     = (opcode == OPW'(OP_RTYPE));
        op_lw    = (opcode == OPW'(OP_LW));
        op_sw    = (opcode == OPW'(OP_SW));
        op_beq   = (opcode == OPW'(OP_BEQ));
        op_bne   = (opcode == OPW'(OP_BNE));
        op_addi  = (opcode == OPW'(OP_ADDI));
        op_j     = (opcode == OPW'(OP_J));
        op_legal = op_r | op_lw | op_sw | op_beq | op_bne | op_addi | op_j;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:      state_d = S_FETCH;
            S_FETCH:     state_d = S_DECODE;
            S_DECODE: begin
                if (op_r)                state_d = S_R_EXEC;
                else if (op_lw || op_sw) state_d = S_MEM_ADDR;
                else if (op_beq || op_bne) state_d = S_BRANCH;
                else if (op_addi)        state_d = S_ADDI_EXEC;
                else if (op_j)           state_d = S_JUMP;
                else                     state_d = S_FETCH;
            end
            S_R_EXEC:    state_d = fn_illegal ? S_FETCH : S_R_WB;
            S_MEM_ADDR:  state_d = op_lw ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    // Control word for the state being entered; everything not set stays 0.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_ren   = 1'b1;
                ctrl_d.ir_write  = 1'b1;
                ctrl_d.alu_src_b = SRCB_FOUR;
                ctrl_d.alu_op    = ALU_ADD;
                ctrl_d.pc_source = PCS_ALU;
                ctrl_d.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl_d.alu_src_b = SRCB_IMM_SH;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_R_EXEC: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_src_b  = SRCB_B;
                ctrl_d.alu_op     = fn_alu_op;
                ctrl_d.illegal    = fn_illegal;
                ctrl_d.instr_done = fn_illegal;
            end
            S_R_WB: begin
                ctrl_d.reg_dst    = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.instr_done = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl_d.mem_ren = 1'b1;
                ctrl_d.iord    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_d.mem_wen    = 1'b1;
                ctrl_d.iord       = 1'b1;
                ctrl_d.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_src_b  = SRCB_B;
                ctrl_d.alu_op     = ALU_SUB;
                ctrl_d.pc_source  = PCS_ALUOUT;
                ctrl_d.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_d.pc_source  = PCS_JUMP;
                ctrl_d.pc_write   = 1'b1;
                ctrl_d.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.instr_done = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_INIT;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign pc_write   = ctrl_q.pc_write |
                        ((state_q == S_BRANCH) & (zero ^ op_bne));
    assign iord       = ctrl_q.iord;
    assign mem_ren    = ctrl_q.mem_ren;
    assign mem_wen    = ctrl_q.mem_wen;
    assign ir_write   = ctrl_q.ir_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign pc_source  = ctrl_q.pc_source;
    assign alu_op     = O'(ctrl_q.alu_op);
    assign instr_done = ctrl_q.instr_done;
    assign illegal    = ctrl_q.illegal | ((state_q == S_DECODE) & ~op_legal);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed and random-stream bench for multicycle_control; expected control
// words per state are written out by hand below.
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       zero = 1'b0;
    logic       pc_write, iord, mem_ren, mem_wen, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op;
    logic [18:0] obs;

    int n_vec  = 0;
    int n_miss = 0;

    multicycle_control #(.O(4), .OPW(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    assign obs = {pc_write, iord, mem_ren, mem_wen, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, pc_source, alu_op, instr_done, illegal};

    function automatic logic [18:0] cw(input logic pcw, input logic io, input logic ren,
                                       input logic wen, input logic irw, input logic rdst,
                                       input logic m2r, input logic rw, input logic a,
                                       input logic [1:0] b, input logic [1:0] pcs,
                                       input logic [3:0] op, input logic done,
                                       input logic ill);
        return {pcw, io, ren, wen, irw, rdst, m2r, rw, a, b, pcs, op, done, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [18:0] W_FETCH, W_DEC, W_DEC_ILL, W_MADDR, W_MRD, W_MWB, W_MWR;
    logic [18:0] W_RWB, W_JUMP, W_AEXEC, W_AWB, W_REXEC_ILL;

    function automatic logic [18:0] w_rexec(input logic [3:0] op);
        return cw(0,0,0,0,0,0,0,0,1,2'd0,2'd0,op,0,0);
    endfunction

    function automatic logic [18:0] w_branch(input logic pcw);
        return cw(pcw,0,0,0,0,0,0,0,1,2'd0,2'd1,4'd6,1,0);
    endfunction

    // Starts in a FETCH cycle; leaves the bench in the next FETCH cycle.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int n,
                             input logic [18:0] e0, input logic [18:0] e1,
                             input logic [18:0] e2, input logic [18:0] e3,
                             input logic [18:0] e4);
        logic [18:0] e [5];
        e = '{e0, e1, e2, e3, e4};
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            chk($sformatf("%s_c%0d", tag, k + 1), 32'(obs), 32'(e[k]));
        end
        tick();
    endtask

    logic [5:0] rnd_ops [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02,
                                 6'h3F, 6'h01, 6'h10};
    logic [5:0] rnd_fns [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

    initial begin
        int len, dones, legal, ovl, misalign;
        logic [5:0] op;

        W_FETCH     = cw(1,0,1,0,1,0,0,0,0,2'd1,2'd0,4'd2,0,0);
        W_DEC       = cw(0,0,0,0,0,0,0,0,0,2'd3,2'd0,4'd2,0,0);
        W_DEC_ILL   = cw(0,0,0,0,0,0,0,0,0,2'd3,2'd0,4'd2,0,1);
        W_MADDR     = cw(0,0,0,0,0,0,0,0,1,2'd2,2'd0,4'd2,0,0);
        W_MRD       = cw(0,1,1,0,0,0,0,0,0,2'd0,2'd0,4'd0,0,0);
        W_MWB       = cw(0,0,0,0,0,0,1,1,0,2'd0,2'd0,4'd0,1,0);
        W_MWR       = cw(0,1,0,1,0,0,0,0,0,2'd0,2'd0,4'd0,1,0);
        W_RWB       = cw(0,0,0,0,0,1,0,1,0,2'd0,2'd0,4'd0,1,0);
        W_JUMP      = cw(1,0,0,0,0,0,0,0,0,2'd0,2'd2,4'd0,1,0);
        W_AEXEC     = W_MADDR;
        W_AWB       = cw(0,0,0,0,0,0,0,1,0,2'd0,2'd0,4'd0,1,0);
        W_REXEC_ILL = cw(0,0,0,0,0,0,0,0,1,2'd0,2'd0,4'd2,1,1);

        tick();
        tick();
        chk("reset_hold", 32'(obs), 32'd0);
        reset = 1'b1;
        chk("init_cycle", 32'(obs), 32'd0);
        tick();
        chk("first_fetch", 32'(obs), 32'(W_FETCH));

        // lw interrupted in MEM_ADDR by a 3-cycle reset
        opcode = 6'h23;
        tick();
        chk("lw_int_dec", 32'(obs), 32'(W_DEC));
        tick();
        chk("lw_int_addr", 32'(obs), 32'(W_MADDR));
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid_rst_%0d", k), 32'(obs), 32'd0);
        end
        reset = 1'b1;
        chk("rel_init", 32'(obs), 32'd0);
        tick();

        run_instr("r_sub",  6'h00, 6'h22, 0, 4, W_FETCH, W_DEC, w_rexec(4'd6),  W_RWB, 0);
        run_instr("r_add",  6'h00, 6'h20, 0, 4, W_FETCH, W_DEC, w_rexec(4'd2),  W_RWB, 0);
        run_instr("r_and",  6'h00, 6'h24, 1, 4, W_FETCH, W_DEC, w_rexec(4'd0),  W_RWB, 0);
        run_instr("r_or",   6'h00, 6'h25, 0, 4, W_FETCH, W_DEC, w_rexec(4'd1),  W_RWB, 0);
        run_instr("r_nor",  6'h00, 6'h27, 0, 4, W_FETCH, W_DEC, w_rexec(4'd12), W_RWB, 0);
        run_instr("r_slt",  6'h00, 6'h2A, 0, 4, W_FETCH, W_DEC, w_rexec(4'd7),  W_RWB, 0);
        run_instr("lw",     6'h23, 6'h00, 0, 5, W_FETCH, W_DEC, W_MADDR, W_MRD, W_MWB);
        run_instr("sw",     6'h2B, 6'h00, 0, 4, W_FETCH, W_DEC, W_MADDR, W_MWR, 0);
        run_instr("addi",   6'h08, 6'h00, 0, 4, W_FETCH, W_DEC, W_AEXEC, W_AWB, 0);
        run_instr("beq_z1", 6'h04, 6'h00, 1, 3, W_FETCH, W_DEC, w_branch(1), 0, 0);
        run_instr("beq_z0", 6'h04, 6'h00, 0, 3, W_FETCH, W_DEC, w_branch(0), 0, 0);
        run_instr("bne_z1", 6'h05, 6'h00, 1, 3, W_FETCH, W_DEC, w_branch(0), 0, 0);
        run_instr("bne_z0", 6'h05, 6'h00, 0, 3, W_FETCH, W_DEC, w_branch(1), 0, 0);
        run_instr("jump",   6'h02, 6'h00, 0, 3, W_FETCH, W_DEC, W_JUMP, 0, 0);
        run_instr("ill_op", 6'h3F, 6'h00, 0, 2, W_FETCH, W_DEC_ILL, 0, 0, 0);
        run_instr("ill_fn", 6'h00, 6'h00, 0, 3, W_FETCH, W_DEC, W_REXEC_ILL, 0, 0);
        chk("after_ill_fn", 32'(obs), 32'(W_FETCH));

        dones = 0; legal = 0; ovl = 0; misalign = 0;
        for (int i = 0; i < 1000; i++) begin
            op     = rnd_ops[$urandom_range(0, 9)];
            opcode = op;
            funct  = rnd_fns[$urandom_range(0, 5)];
            zero   = 1'($urandom_range(0, 1));
            case (op)
                6'h23:                      len = 5;
                6'h00, 6'h2B, 6'h08:        len = 4;
                6'h04, 6'h05, 6'h02:        len = 3;
                default:                    len = 2;
            endcase
            if (len != 2) legal++;
            for (int c = 0; c < len; c++) begin
                if (c > 0) tick();
                if (mem_ren && mem_wen) ovl++;
                if (reg_write && mem_wen) ovl++;
                if ((c == 0) != ir_write) misalign++;
                if (instr_done) begin
                    if (c == len - 1) dones++;
                    else misalign++;
                end
            end
            tick();
        end
        chk("rnd_ren_wen_overlap", 32'(ovl), 32'd0);
        chk("rnd_instr_done_count", 32'(dones), 32'(legal));
        chk("rnd_latency_align", 32'(misalign), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the shared 32-bit datapath (ALU, single-port Memory, RegFile) of the multicycle MIPS core.
- Decodes opcode and funct from the instruction register.
- Drives every mux select, enable and ALU opcode.
- Guarantees Memory `ren` and `wen` are never both high.

Parameters:
- O, 4, ALU op width; must match the ALU `op` port.
- OPW, 6, opcode and funct field width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled on rising clock edge
- opcode  in  OPW  IR[31:26]; stable from the end of FETCH onward
- funct  in  OPW  IR[5:0]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC load enable (includes conditional branch resolution)
- iord  out  1  Memory address select: 0=PC, 1=ALUOut
- mem_ren  out  1  Memory read enable
- mem_wen  out  1  Memory write enable
- ir_write  out  1  IR load enable
- reg_dst  out  1  write-register select: 0=rt, 1=rd
- mem_to_reg  out  1  write-data select: 0=ALUOut, 1=MDR
- reg_write  out  1  RegFile `wen`; RegFile writes on the falling edge inside the asserted cycle
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  0=B, 1=const 4, 2=sign-extended imm, 3=sign-extended imm<<2
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target
- alu_op  out  O  ALU op: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct

Behaviour:
- Reset (reset==0 at a rising edge):
  - state <= INIT
  - all outputs 0 while in INIT
  - reset overrides every state, including mid-instruction; no partial write may follow
- INIT -> FETCH unconditionally.
- Outputs not listed for a state are 0.
- FETCH:
  - asserts mem_ren, iord=0, ir_write, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0, pc_write
  - -> DECODE
- DECODE:
  - asserts alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut)
  - next state by opcode:
    - 0x00 -> R_EXEC
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 or 0x05 -> BRANCH
    - 0x08 -> ADDI_EXEC
    - 0x02 -> JUMP
    - other -> FETCH with illegal=1
- R_EXEC:
  - alu_src_a=1, alu_src_b=0
  - alu_op from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT
  - -> R_WB
  - unsupported funct: alu_op=ADD, illegal=1, instr_done=1, -> FETCH; no write-back
- R_WB: reg_dst=1, mem_to_reg=0, reg_write, instr_done -> FETCH
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD -> MEM_READ if opcode 0x23, else MEM_WRITE
- MEM_READ: mem_ren, iord=1 -> MEM_WB
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write, instr_done -> FETCH
- MEM_WRITE: mem_wen, iord=1, mem_ren=0, instr_done -> FETCH
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_source=1, instr_done
  - pc_write = zero for beq, ~zero for bne (combinational on zero)
  - -> FETCH
- JUMP: pc_source=2, pc_write, instr_done -> FETCH
- ADDI_EXEC: alu_src_a=1, alu_src_b=2, alu_op=ADD -> ADDI_WB
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write, instr_done -> FETCH
- Latencies, FETCH to instr_done inclusive:
  - R 4, lw 5, sw 4, addi 4, beq/bne 3, j 3
  - illegal opcode: 2 cycles, no instr_done
- Invariants:
  - mem_ren & mem_wen == 0 in every state
  - reg_write never coincides with mem_wen
  - pc_write is asserted only in FETCH, BRANCH and JUMP

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - state encoding (4-bit: INIT, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB)
  - opcode/funct constants
  - ALU op codes (reused by the ALU)
  - alu_src_b and pc_source encodings
- One sub-module `alu_funct_decode`: combinational funct -> {alu_op, illegal}, instantiated for R_EXEC.

Test Plan:
- Hold reset=0 for 3 cycles mid-lw, release -> INIT for 1 cycle, all outputs 0, then FETCH with mem_ren=1, ir_write=1, pc_write=1.
- R-type sub (opcode 0x00, funct 0x22):
  - R_EXEC alu_op=6, alu_src_a=1, alu_src_b=0
  - R_WB reg_write=1, reg_dst=1
  - instr_done on cycle 4
- lw (0x23): mem_ren=1 with iord=1 in cycle 4, reg_write=1 with mem_to_reg=1 in cycle 5; sw (0x2B): mem_wen=1, mem_ren=0 in cycle 4, no reg_write anywhere.
- Branches:
  - beq (0x04) with zero=1 -> pc_write=1, pc_source=1 in cycle 3
  - beq with zero=0 -> pc_write=0
  - bne (0x05) gives the inverse for each zero value
- Illegal cases:
  - opcode 0x3F -> illegal pulse in DECODE, next cycle FETCH
  - funct 0x00 -> illegal in R_EXEC, no reg_write
- Random instruction stream of 1000 instructions -> assert mem_ren&mem_wen==0 every cycle; instr_done count matches legal instructions issued.
